// File: rtl/mod192_reduce_pipe_pkg.sv
// Shared constants for the 192-bit to 64-bit Goldilocks-prime reduction pipeline.
package mod_pkg;

    localparam int D_W     = 192;   // operand width
    localparam int P_W     = 64;    // residue width
    localparam int CHUNK_W = 32;    // width of each operand chunk a..f

    // Bit offsets of the 32-bit chunks inside the 192-bit operand
    localparam int OFF_A = 160;
    localparam int OFF_B = 128;
    localparam int OFF_C = 96;
    localparam int OFF_D = 64;
    localparam int OFF_E = 32;
    localparam int OFF_F = 0;

    localparam int SUM_W  = 65;     // t1 / t4: sum of two 64-bit values
    localparam int DIFF_W = 66;     // t6: signed t1 - t4
    localparam int CAND_W = 68;     // signed t6 + k*p, k in -2..3

    localparam int STAGES = 4;      // operand capture, S1, S2, S3

    localparam logic [P_W-1:0] PRIME_P = 64'hFFFFFFFF00000001;

endpackage

// File: rtl/mod192_reduce_pipe_pd.sv
// Operand pre-decomposition: splits the 192-bit operand into the four 64-bit
// terms of the reduction identity and supplies bitwise-inverted forms used by
// the downstream subtractors.
module Mod192PD
    import mod_pkg::*;
(
    input  logic [D_W-1:0]    a_in,
    input  logic [SUM_W-1:0]  n_in,
    input  logic [DIFF_W-1:0] t6_in,
    output logic [P_W-1:0]    ef_d,
    output logic [P_W-1:0]    da_d,
    output logic [P_W-1:0]    bc_d,
    output logic [P_W-1:0]    ad_d,
    output logic [SUM_W-1:0]  n_inv,
    output logic [DIFF_W-1:0] t6_inv
);

    logic [CHUNK_W-1:0] ch_a, ch_b, ch_c, ch_d, ch_e, ch_f;

    // Chunk split, term concatenation and operand inversion
    always_comb begin
        ch_a   = a_in[OFF_A +: CHUNK_W];
        ch_b   = a_in[OFF_B +: CHUNK_W];
        ch_c   = a_in[OFF_C +: CHUNK_W];
        ch_d   = a_in[OFF_D +: CHUNK_W];
        ch_e   = a_in[OFF_E +: CHUNK_W];
        ch_f   = a_in[OFF_F +: CHUNK_W];
        ef_d   = {ch_e, ch_f};
        da_d   = {ch_d, ch_a};
        bc_d   = {ch_b, ch_c};
        ad_d   = {ch_a, ch_d};
        n_inv  = ~n_in;
        t6_inv = ~t6_in;
    end

endmodule

// File: rtl/mod192_reduce_pipe.sv
// Pipelined reduction of a 192-bit operand modulo p = 2^64 - 2^32 + 1.
// Uses 2^96 == -1 (mod p): A == {e,f} + {d,a} - {b,c} - {a,d}.
// Stages: operand capture -> S1 (t1, t4) -> S2 (t6 = t1 - t4) -> S3 (t6 + k*p).
// A single output-held stall freezes the whole pipe.
module mod192_reduce_pipe
    import mod_pkg::*;
#(
    parameter int                   D_WIDTH = 192,
    parameter int                   P_WIDTH = 64,
    parameter logic [P_WIDTH-1:0]   PRIME   = PRIME_P
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] A_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [P_WIDTH-1:0] Res_out,
    output logic               valid_out,
    input  logic               ready_in
);

    logic [STAGES-1:0]  vld_pipe_q, vld_pipe_d;
    logic [D_WIDTH-1:0] op_q, op_d;
    logic [SUM_W-1:0]   t1_q, t1_d, t4_q, t4_d;
    logic [DIFF_W-1:0]  t6_q, t6_d;
    logic [P_WIDTH-1:0] res_q, res_d, res_sel;

    logic [P_W-1:0]     ef, da, bc, ad;
    logic [SUM_W-1:0]   t4_inv;
    logic [DIFF_W-1:0]  t6_inv;

    logic               adv;
    logic [CAND_W-1:0]  p1, p2, p3, t6_sx, t6n_sx;
    logic [CAND_W-1:0]  cand [6];

    Mod192PD u_pd (
        .a_in   (op_q),
        .n_in   (t4_q),
        .t6_in  (t6_q),
        .ef_d   (ef),
        .da_d   (da),
        .bc_d   (bc),
        .ad_d   (ad),
        .n_inv  (t4_inv),
        .t6_inv (t6_inv)
    );

    // Output-held stall; everything advances together when not stalled
    always_comb begin
        adv       = !(vld_pipe_q[STAGES-1] && !ready_in);
        ready_out = adv;
        valid_out = vld_pipe_q[STAGES-1];
        Res_out   = res_q;
    end

    // S3 candidates t6 + k*p for k = -2..3; negative k subtracts via ~(~t6 + |k|p)
    always_comb begin
        p1      = CAND_W'(PRIME);
        p2      = p1 << 1;
        p3      = p2 + p1;
        t6_sx   = {{(CAND_W-DIFF_W){t6_q[DIFF_W-1]}}, t6_q};
        t6n_sx  = {{(CAND_W-DIFF_W){t6_inv[DIFF_W-1]}}, t6_inv};
        cand[0] = ~(t6n_sx + p2);
        cand[1] = ~(t6n_sx + p1);
        cand[2] = t6_sx;
        cand[3] = t6_sx + p1;
        cand[4] = t6_sx + p2;
        cand[5] = t6_sx + p3;
        res_sel = '0;
        for (int i = 0; i < 6; i++) begin
            if (!cand[i][CAND_W-1] && (cand[i] < p1))
                res_sel = cand[i][P_WIDTH-1:0];
        end
    end

    // Next-state: valid shift and per-stage data loads gated by incoming valid
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        op_d       = op_q;
        t1_d       = t1_q;
        t4_d       = t4_q;
        t6_d       = t6_q;
        res_d      = res_q;
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[STAGES-2:0], valid_in};
            if (valid_in)
                op_d = A_in;
            if (vld_pipe_q[0]) begin
                t1_d = {1'b0, ef} + {1'b0, da};
                t4_d = {1'b0, bc} + {1'b0, ad};
            end
            // t1 - t4 as t1 + ~t4 + 1, sign-extended to 66 bits
            if (vld_pipe_q[1])
                t6_d = {1'b0, t1_q} + {1'b1, t4_inv} + DIFF_W'(1);
            if (vld_pipe_q[2])
                res_d = res_sel;
        end
    end

    // State registers; reset clears valids and the visible result
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            res_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            res_q      <= res_d;
        end
        op_q <= op_d;
        t1_q <= t1_d;
        t4_q <= t4_d;
        t6_q <= t6_d;
    end

endmodule

// File: tb/tb_mod192_reduce_pipe.sv
// Bench for mod192_reduce_pipe: directed literal vectors, stall and reset
// scenarios, then constrained-random traffic, all scored against A % p.
module tb_mod192_reduce_pipe;

    localparam logic [63:0] P = 64'hFFFFFFFF00000001;

    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] A_in;
    logic         valid_in;
    logic         ready_out;
    logic [63:0]  Res_out;
    logic         valid_out;
    logic         ready_in;

    int errors = 0;
    int checks = 0;
    int n_deliv = 0;
    logic [63:0] exp_q[$];

    mod192_reduce_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .A_in      (A_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .Res_out   (Res_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mod(input logic [191:0] a);
        logic [191:0] r;
        r = a % {128'd0, P};
        return r[63:0];
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: record accepts, check deliveries, order, range and hold stability
    bit          held = 0;
    logic [63:0] held_val;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (held) begin
                chk(valid_out == 1'b1, "hold_valid", 64'(valid_out), 64'd1);
                chk(Res_out == held_val, "hold_data", Res_out, held_val);
            end
            chk(ready_out == !(valid_out && !ready_in), "ready_rule", 64'(ready_out), 64'(!(valid_out && !ready_in)));
            if (valid_in && ready_out)
                exp_q.push_back(ref_mod(A_in));
            if (valid_out && ready_in) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", Res_out, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk(Res_out == e, "result", Res_out, e);
                    chk(Res_out < P, "range", Res_out, P);
                end
            end
            held     = valid_out && !ready_in;
            held_val = Res_out;
        end
    end

    task automatic drain();
        valid_in = 0;
        ready_in = 1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Single operand with literal expectation and 3-edge latency measurement
    task automatic send_one(input logic [191:0] a, input logic [63:0] exp, input string nm);
        int lat;
        chk(ref_mod(a) == exp, {"model_", nm}, ref_mod(a), exp);
        @(posedge clk); #1;
        A_in = a; valid_in = 1; ready_in = 1;
        #1;
        chk(ready_out == 1'b1, {"rdy_", nm}, 64'(ready_out), 64'd1);
        @(posedge clk); #1;
        valid_in = 0;
        lat = 0;
        while (!valid_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(lat == 3, {"lat_", nm}, 64'(lat), 64'd3);
        chk(Res_out == exp, {"res_", nm}, Res_out, exp);
        drain();
    endtask

    function automatic logic [191:0] rand_op();
        logic [191:0] v;
        int sel;
        sel = $urandom_range(0, 4);
        for (int j = 0; j < 6; j++) v[32*j +: 32] = $urandom();
        case (sel)
            1: v = '1;
            2: v = {128'd0, P} + 192'($urandom_range(0, 3)) - 192'd2;
            3: for (int j = 0; j < 6; j++)
                   v[32*j +: 32] = ($urandom_range(0, 2) == 0) ? 32'h0 :
                                   (($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h1);
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] vec [8];
        int idx;
        int d0;
        bit acc;

        rst = 1; A_in = '0; valid_in = 1; ready_in = 1;
        repeat (3) @(posedge clk);
        #1;
        chk(valid_out == 1'b0, "rst_valid", 64'(valid_out), 64'd0);
        chk(Res_out == 64'd0, "rst_res", Res_out, 64'd0);
        valid_in = 0;
        rst = 0;
        @(posedge clk); #1;
        chk(ready_out == 1'b1, "rst_ready", 64'(ready_out), 64'd1);
        chk(valid_out == 1'b0, "rst_no_leak", 64'(valid_out), 64'd0);

        // Directed literals
        send_one(192'd0, 64'd0, "zero");
        send_one(192'd1 << 96, 64'hFFFFFFFF00000000, "2p96");
        send_one(192'd1 << 64, 64'h00000000FFFFFFFF, "2p64");
        send_one({128'd0, P}, 64'd0, "p");
        send_one({192{1'b1}}, 64'd0, "ones");
        // (2^64-1)*2^96 == -(2^64-1) == -(2^32-2) == p - 2^32 + 2
        send_one({32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 96'h0}, 64'hFFFFFFFE00000003, "bc");
        send_one({128'd0, P} + 192'd5, 64'd5, "p_plus5");

        // Eight back-to-back operands, consumer stalls on cycles 4..6
        for (int i = 0; i < 8; i++) vec[i] = {32'(i * 7 + 1), 64'h0123456789ABCDEF ^ 64'(i), 32'hF0F0F0F0, 64'(i) << 40};
        d0 = n_deliv;
        idx = 0; acc = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (acc) idx++;
            ready_in = !(c >= 4 && c <= 6);
            valid_in = (idx < 8);
            A_in     = (idx < 8) ? vec[idx] : '0;
            #1;
            acc = valid_in && ready_out;
            if (c >= 4 && c <= 6)
                chk(ready_out == 1'b0, "stall_ready", 64'(ready_out), 64'd0);
        end
        drain();
        chk(n_deliv - d0 == 8, "stall_count", 64'(n_deliv - d0), 64'd8);

        // Reset with two operands in flight plus an operand offered during reset
        @(posedge clk); #1;
        A_in = 192'd12345; valid_in = 1; ready_in = 1;
        @(posedge clk); #1;
        A_in = 192'd67890;
        @(posedge clk); #1;
        A_in = 192'd999; rst = 1;
        @(posedge clk); #1;
        rst = 0; valid_in = 0;
        chk(valid_out == 1'b0, "rst_mid_valid", 64'(valid_out), 64'd0);
        chk(ready_out == 1'b1, "rst_mid_ready", 64'(ready_out), 64'd1);
        d0 = n_deliv;
        repeat (6) @(posedge clk);
        #1;
        chk(n_deliv == d0, "rst_flushed", 64'(n_deliv - d0), 64'd0);
        send_one(192'd1 << 96, 64'hFFFFFFFF00000000, "post_rst");

        // Random traffic; producer holds an operand until it is accepted
        acc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!valid_in || acc) begin
                valid_in = ($urandom_range(0, 3) != 0);
                A_in     = rand_op();
            end
            ready_in = ($urandom_range(0, 3) != 0);
            #1;
            acc = valid_in && ready_out;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
